uart_alu_cmd_ctrl: RTL and testbench

Byte-level command controller between the UART receiver/transmitter and a parametrised-width ALU, successor to the fixed 8-bit config/display path in tp2_top. It parses the CONFIG (0xCD) and DISPLAY (0xD1) command protocol with multi-byte operands and commits A, B and OP to the ALU atomically. It serialises the result and flags back to the transmitter, and adds an inter-byte timeout plus NACK responses for malformed traffic.

---
 rtl/uart_alu_cmd_ctrl.sv | 164 ++++++++++++++++
 tb/tb_uart_alu_cmd_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_cmd_ctrl.sv
// Byte-level CONFIG/DISPLAY command controller between a UART and a DATA_WIDTH ALU.
// Receives multi-byte operands, commits A/B/OP atomically, and serialises result+flags or a NACK.
module uart_alu_cmd_ctrl #(
  parameter int         DATA_WIDTH     = 16,
  parameter int         OP_WIDTH       = 6,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] CMD_CONFIG     = 8'hCD,
  parameter logic [7:0] CMD_DISPLAY    = 8'hD1,
  parameter logic [7:0] NACK_BYTE      = 8'hEE
) (
  input  logic                  CLK100MHZ,
  input  logic                  BTN_CENTER,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [OP_WIDTH-1:0]   alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_overflow,
  output logic                  cfg_done,
  output logic                  err_timeout
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(NB + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = $clog2(NB + 2);
  localparam int TXQ_W = DATA_WIDTH + 8;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RX_A,
    RX_B,
    RX_OP,
    TX_LOAD,
    TX_WAIT
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [TO_W-1:0]      to_cnt;
  logic [DATA_WIDTH-1:0] shadow_a;
  logic [DATA_WIDTH-1:0] shadow_b;
  logic [TXQ_W-1:0]     tx_shift;
  logic [CNT_W-1:0]     tx_left;
  logic                 tx_guard;
  logic                 cfg_pend;

  // NOTE: every register here is updated with <= so all reads in this block see pre-edge values.
  always_ff @(posedge CLK100MHZ or posedge BTN_CENTER) begin
    if (BTN_CENTER) begin
      state       <= IDLE;
      idx         <= '0;
      to_cnt      <= '0;
      shadow_a    <= '0;
      shadow_b    <= '0;
      tx_shift    <= '0;
      tx_left     <= '0;
      tx_guard    <= 1'b0;
      cfg_pend    <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      cfg_done    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      err_timeout <= 1'b0;
      cfg_done    <= cfg_pend;
      cfg_pend    <= 1'b0;

      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (rx_valid) begin
            if (rx_data == CMD_CONFIG) begin
              idx   <= '0;
              state <= RX_A;
            end else if (rx_data == CMD_DISPLAY) begin
              // Snapshot so later ALU input changes cannot corrupt the reply.
              tx_shift <= {6'b0, alu_overflow, alu_zero, alu_result};
              tx_left  <= CNT_W'(NB + 1);
              state    <= TX_LOAD;
            end else begin
              tx_shift <= TXQ_W'(NACK_BYTE);
              tx_left  <= CNT_W'(1);
              state    <= TX_LOAD;
            end
          end
        end

        RX_A, RX_B, RX_OP: begin
          if (rx_valid) begin
            to_cnt <= '0;
            if (state == RX_OP) begin
              alu_a    <= shadow_a;
              alu_b    <= shadow_b;
              alu_op   <= rx_data[OP_WIDTH-1:0];
              cfg_pend <= 1'b1;
              state    <= IDLE;
            end else begin
              // Little-endian operand assembly: byte idx lands in bits [8*idx +: 8].
              for (int i = 0; i < NB; i++) begin
                if (idx == IDX_W'(i)) begin
                  if (state == RX_A) shadow_a[8*i +: 8] <= rx_data;
                  else               shadow_b[8*i +: 8] <= rx_data;
                end
              end
              if (idx == IDX_LAST) begin
                idx   <= '0;
                state <= (state == RX_A) ? RX_B : RX_OP;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
          end else if (to_cnt == TO_LAST) begin
            to_cnt      <= '0;
            idx         <= '0;
            shadow_a    <= '0;
            shadow_b    <= '0;
            err_timeout <= 1'b1;
            tx_shift    <= TXQ_W'(NACK_BYTE);
            tx_left     <= CNT_W'(1);
            state       <= TX_LOAD;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        TX_LOAD: begin
          if (!tx_busy) begin
            tx_data  <= tx_shift[7:0];
            tx_shift <= tx_shift >> 8;
            tx_left  <= tx_left - CNT_W'(1);
            tx_start <= 1'b1;
            tx_guard <= 1'b1;
            state    <= TX_WAIT;
          end
        end

        TX_WAIT: begin
          // tx_busy only rises the cycle after tx_start, so skip that first cycle.
          if (tx_guard) begin
            tx_guard <= 1'b0;
          end else if (!tx_busy) begin
            state <= (tx_left == '0) ? IDLE : TX_LOAD;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_cmd_ctrl.sv
// Randomised self-checking bench for uart_alu_cmd_ctrl with a UART transmitter model,
// a behavioural ALU, and a transaction-level reference of committed A/B/OP.
module tb_uart_alu_cmd_ctrl;

  localparam int         DW      = 16;
  localparam int         NB      = DW / 8;
  localparam int         TO      = 2000;
  localparam logic [7:0] C_CFG   = 8'hCD;
  localparam logic [7:0] C_DISP  = 8'hD1;
  localparam logic [7:0] C_NACK  = 8'hEE;

  logic          clk = 1'b0;
  logic          tb_reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [5:0]    alu_op;
  logic          alu_zero, alu_overflow;
  logic          cfg_done, err_timeout;

  uart_alu_cmd_ctrl #(
    .DATA_WIDTH(DW), .OP_WIDTH(6), .TIMEOUT_CYCLES(TO),
    .CMD_CONFIG(C_CFG), .CMD_DISPLAY(C_DISP), .NACK_BYTE(C_NACK)
  ) dut (
    .CLK100MHZ(clk), .BTN_CENTER(tb_reset),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .cfg_done(cfg_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Returns {overflow, zero, result}.
  function automatic logic [DW+1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [5:0] op);
    logic [DW-1:0] r;
    logic          v;
    v = 1'b0;
    case (op)
      6'h20: begin r = a + b; v = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
      6'h22: begin r = a - b; v = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h02: r = a >> b[3:0];
      default: r = '0;
    endcase
    return {v, (r == '0), r};
  endfunction

  always_comb {alu_overflow, alu_zero, alu_result} = alu_ref(alu_a, alu_b, alu_op);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: captures bytes, busy from the cycle after tx_start for a random length.
  logic [7:0] tx_q[$];
  logic       tx_pend = 1'b0;
  int         busy_left = 0;
  int         overlap = 0;
  int         cfg_seen = 0;
  int         err_seen = 0;

  initial tx_busy = 1'b0;

  always @(negedge clk) begin
    if (tb_reset) begin
      tx_pend   = 1'b0;
      tx_busy   = 1'b0;
      busy_left = 0;
    end else begin
      if (tx_start && (tx_busy || tx_pend)) overlap++;
      if (tx_start) begin
        tx_q.push_back(tx_data);
        tx_pend = 1'b1;
      end else if (tx_pend) begin
        tx_pend   = 1'b0;
        tx_busy   = 1'b1;
        busy_left = $urandom_range(2, 10);
      end else if (tx_busy) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
    end
    if (cfg_done)    cfg_seen++;
    if (err_timeout) err_seen++;
  end

  // Reference model: committed configuration as seen by the ALU.
  logic [DW-1:0] m_a = '0, m_b = '0;
  logic [5:0]    m_op = '0;
  int            n_cfg = 0;

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic wait_tx(input int n);
    int cyc = 0;
    while (tx_q.size() < n && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("tx_arrival", 32'(tx_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while ((tx_busy || tx_pend) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("tx_idle_bound", 32'(cyc < 500), 32'd1);
    repeat (6) @(negedge clk);
  endtask

  task automatic send_config(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [7:0] opb, input int stall);
    send_byte(C_CFG);
    for (int i = 0; i < NB; i++) begin
      send_byte(a[8*i +: 8]);
      if (i == 0 && stall > 0) repeat (stall) @(negedge clk);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    for (int i = 0; i < NB; i++) begin
      send_byte(b[8*i +: 8]);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    check("alu_a_hold", 32'(alu_a), 32'(m_a));
    check("alu_op_hold", 32'(alu_op), 32'(m_op));
    send_byte(opb);
    m_a = a;
    m_b = b;
    m_op = opb[5:0];
    n_cfg++;
    check("alu_a", 32'(alu_a), 32'(m_a));
    check("alu_b", 32'(alu_b), 32'(m_b));
    check("alu_op", 32'(alu_op), 32'(m_op));
    check("cfg_done_lat1", 32'(cfg_done), 32'd0);
    @(negedge clk);
    check("cfg_done_lat2", 32'(cfg_done), 32'd1);
    @(negedge clk);
    check("cfg_done_width", 32'(cfg_done), 32'd0);
  endtask

  function automatic logic [NB*8+7:0] expect_disp();
    logic [DW+1:0] r;
    r = alu_ref(m_a, m_b, m_op);
    return {6'b0, r[DW+1], r[DW], r[DW-1:0]};
  endfunction

  task automatic do_display(input logic [NB*8+7:0] exp, input bit drop);
    tx_q.delete();
    send_byte(C_DISP);
    check("disp_lat_early", 32'(tx_start), 32'd0);
    @(negedge clk);
    check("disp_lat", 32'(tx_start), 32'd1);
    if (drop) send_byte(8'($urandom));
    wait_tx(NB + 1);
    wait_idle();
    check("disp_len", 32'(tx_q.size()), 32'(NB + 1));
    if (tx_q.size() == NB + 1)
      for (int i = 0; i < NB + 1; i++) check("disp_byte", 32'(tx_q[i]), 32'(exp[8*i +: 8]));
  endtask

  task automatic do_unknown(input logic [7:0] b);
    tx_q.delete();
    send_byte(b);
    wait_tx(1);
    wait_idle();
    check("nack_len", 32'(tx_q.size()), 32'd1);
    if (tx_q.size() == 1) check("nack_byte", 32'(tx_q[0]), 32'(C_NACK));
    check("nack_alu_a", 32'(alu_a), 32'(m_a));
    check("nack_alu_op", 32'(alu_op), 32'(m_op));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ops[6] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h02};
    logic [7:0] ub;
    int         err_base;

    tb_reset = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_tx", 32'({tx_data, tx_start, cfg_done, err_timeout}), 32'd0);
    tb_reset = 1'b0;
    repeat (2) @(negedge clk);

    // DISPLAY before any CONFIG sees A=B=OP=0.
    do_display(expect_disp(), 1'b0);

    // Directed frames.
    send_config(16'h1200, 16'h0F00, 8'h20, 0);
    do_display(24'h00_2100, 1'b0);
    do_unknown(8'h55);
    check("nack_alu_b", 32'(alu_b), 32'h0F00);
    do_display(24'h00_2100, 1'b0);
    send_config(16'h0064, 16'h0064, 8'h22, 0);
    do_display(24'h01_0000, 1'b0);
    send_config(16'h7FFF, 16'h0001, 8'h20, 0);
    do_display(24'h02_8000, 1'b1);

    // Long but legal inter-byte gap.
    err_base = err_seen;
    send_config(16'hA5C3, 16'h0F0F, 8'hE4, TO - 100);
    check("gap_no_timeout", 32'(err_seen - err_base), 32'd0);
    do_display(expect_disp(), 1'b0);

    // Timeout after CD 11 22.
    tx_q.delete();
    err_base = err_seen;
    send_byte(C_CFG);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (TO - 10) @(negedge clk);
    check("timeout_early", 32'(err_seen - err_base), 32'd0);
    check("timeout_no_tx", 32'(tx_q.size()), 32'd0);
    repeat (1000) @(negedge clk);
    check("timeout_pulse", 32'(err_seen - err_base), 32'd1);
    wait_idle();
    check("timeout_len", 32'(tx_q.size()), 32'd1);
    if (tx_q.size() == 1) check("timeout_nack", 32'(tx_q[0]), 32'(C_NACK));
    check("timeout_alu_a", 32'(alu_a), 32'(m_a));
    check("timeout_alu_b", 32'(alu_b), 32'(m_b));
    send_config(16'h3344, 16'h1111, 8'h22, 0);
    do_display(expect_disp(), 1'b0);

    // Randomised traffic.
    for (int it = 0; it < 25; it++) begin
      send_config(DW'($urandom), DW'($urandom),
                  ops[$urandom_range(0, 5)] | 8'($urandom_range(0, 3) << 6), 0);
      do_display(expect_disp(), 1'($urandom_range(0, 1)));
      if (it % 5 == 2) begin
        do begin
          ub = 8'($urandom);
        end while (ub == C_CFG || ub == C_DISP);
        do_unknown(ub);
      end
    end

    // Reset during the second byte of a DISPLAY reply.
    tx_q.delete();
    send_byte(C_DISP);
    wait_tx(2);
    tb_reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_alu", 32'({alu_a, alu_b} != '0 || alu_op != '0), 32'd0);
    check("midrst_tx", 32'({tx_data, tx_start, cfg_done, err_timeout}), 32'd0);
    tb_reset = 1'b0;
    m_a = '0;
    m_b = '0;
    m_op = '0;
    repeat (60) @(negedge clk);
    check("midrst_no_more", 32'(tx_q.size()), 32'd2);
    do_display(expect_disp(), 1'b0);

    check("cfg_pulses", 32'(cfg_seen), 32'(n_cfg));
    check("err_pulses", 32'(err_seen), 32'd1);
    check("tx_overlap", 32'(overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
